// File: rtl/tritone_fetch_pkg.sv
// Shared widths, trit constants and queue-entry type for the ternary fetch unit.
`include "ternary_defs.vh"
package tritone_fetch_pkg;
  localparam int TRITS     = 8;
  localparam int INST_BITS = 18;
  localparam int PC_BITS   = 16;
  localparam int IMEM_BITS = 2 * INST_BITS;

  localparam logic [1:0] TRIT_NEG  = `T_NEG_ONE;
  localparam logic [1:0] TRIT_ZERO = `T_ZERO;
  localparam logic [1:0] TRIT_POS  = `T_POS_ONE;

  typedef struct packed {
    logic [INST_BITS-1:0] inst;
    logic [PC_BITS-1:0]   pc;
  } fq_entry_t;
endpackage

// File: rtl/ternary_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, decode-facing queue head, redirect control.
interface ternary_fetch_unit_if;
  import tritone_fetch_pkg::*;

  logic                 fetch_en;
  logic                 redirect_valid;
  logic [PC_BITS-1:0]   redirect_pc;
  logic [PC_BITS-1:0]   imem_addr;
  logic [IMEM_BITS-1:0] imem_data;
  logic                 fq_valid_a;
  logic                 fq_valid_b;
  logic [INST_BITS-1:0] fq_inst_a;
  logic [INST_BITS-1:0] fq_inst_b;
  logic [PC_BITS-1:0]   fq_pc_a;
  logic [PC_BITS-1:0]   fq_pc_b;
  logic [1:0]           dec_take;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, imem_data, dec_take,
    output imem_addr, fq_valid_a, fq_valid_b, fq_inst_a, fq_inst_b, fq_pc_a, fq_pc_b
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, imem_data, dec_take,
    input  imem_addr, fq_valid_a, fq_valid_b, fq_inst_a, fq_inst_b, fq_pc_a, fq_pc_b
  );
endinterface

// File: rtl/ternary_defs.vh
// Balanced-ternary trit encodings shared by the fetch datapath.
`ifndef TERNARY_DEFS_VH
`define TERNARY_DEFS_VH
`define T_NEG_ONE 2'b11
`define T_ZERO    2'b00
`define T_POS_ONE 2'b01
`endif

// File: rtl/ternary_pc_inc.sv
// 8-trit balanced-ternary incrementer giving PC+1 and PC+2, wrapping modulo 3^8.
`include "ternary_defs.vh"
module ternary_pc_inc
  import tritone_fetch_pkg::*;
(
  input  logic [PC_BITS-1:0] pc,
  output logic [PC_BITS-1:0] pc_plus1,
  output logic [PC_BITS-1:0] pc_plus2
);

  // Carry out of the top trit is dropped, so +3280 + 1 lands on -3280.
  function automatic logic [PC_BITS-1:0] inc1(input logic [PC_BITS-1:0] v);
    logic [PC_BITS-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < TRITS; i++) begin
      if (carry) begin
        case (v[2*i +: 2])
          `T_POS_ONE: r[2*i +: 2] = `T_NEG_ONE;
          `T_NEG_ONE: begin
            r[2*i +: 2] = `T_ZERO;
            carry       = 1'b0;
          end
          default: begin
            r[2*i +: 2] = `T_POS_ONE;
            carry       = 1'b0;
          end
        endcase
      end
    end
    return r;
  endfunction

  always_comb begin
    pc_plus1 = inc1(pc);
    pc_plus2 = inc1(pc_plus1);
  end

endmodule

// File: rtl/ternary_fetch_unit.sv
// Two-wide ternary instruction fetch with a circular fetch queue and redirect flush.
// Optional TRITONE_FETCH_PERF_EN adds saturating stall/redirect counters.
module ternary_fetch_unit
  import tritone_fetch_pkg::*;
#(
  parameter int                 QUEUE_DEPTH = 4,
  parameter logic [PC_BITS-1:0] RESET_PC    = {TRITS{TRIT_ZERO}}
) (
  input logic                  clk,
  input logic                  rst,
  ternary_fetch_unit_if.master bus
`ifdef TRITONE_FETCH_PERF_EN
  ,
  output logic [15:0]          perf_stall_cycles,
  output logic [15:0]          perf_redirects
`endif
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [PC_BITS-1:0] pc_q;
  logic [PC_BITS-1:0] pc_p1;
  logic [PC_BITS-1:0] pc_p2;
  fq_entry_t          queue_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [PTR_W-1:0]   head_b;
  logic [PTR_W-1:0]   tail_b;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   take_req;
  logic [CNT_W-1:0]   take_n;
  logic [CNT_W-1:0]   fetch_n;
  logic               fetch_go;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= QUEUE_DEPTH) s = s - QUEUE_DEPTH;
    return PTR_W'(s);
  endfunction

  ternary_pc_inc u_pc_inc (
    .pc       (pc_q),
    .pc_plus1 (pc_p1),
    .pc_plus2 (pc_p2)
  );

  // Fetch admission uses the start-of-cycle count so a dequeue never enables a same-cycle fetch.
  always_comb begin
    take_req = '0;
    case (bus.dec_take)
      2'd0:    take_req = CNT_W'(0);
      2'd1:    take_req = CNT_W'(1);
      default: take_req = CNT_W'(2);
    endcase
    take_n   = (take_req > count_q) ? count_q : take_req;
    fetch_go = bus.fetch_en && !bus.redirect_valid && (count_q <= CNT_W'(QUEUE_DEPTH - 2));
    fetch_n  = fetch_go ? CNT_W'(2) : CNT_W'(0);
    head_b   = ptr_add(head_q, CNT_W'(1));
    tail_b   = ptr_add(tail_q, CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (bus.redirect_valid) begin
      pc_q    <= bus.redirect_pc;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (fetch_go) begin
        queue_q[tail_q] <= '{inst: bus.imem_data[INST_BITS-1:0], pc: pc_q};
        queue_q[tail_b] <= '{inst: bus.imem_data[IMEM_BITS-1:INST_BITS], pc: pc_p1};
        tail_q          <= ptr_add(tail_q, CNT_W'(2));
        pc_q            <= pc_p2;
      end
      head_q  <= ptr_add(head_q, take_n);
      count_q <= count_q - take_n + fetch_n;
    end
  end

  always_comb begin
    bus.imem_addr  = pc_q;
    bus.fq_valid_a = (count_q >= CNT_W'(1));
    bus.fq_valid_b = (count_q >= CNT_W'(2));
    bus.fq_inst_a  = bus.fq_valid_a ? queue_q[head_q].inst : '0;
    bus.fq_pc_a    = bus.fq_valid_a ? queue_q[head_q].pc   : '0;
    bus.fq_inst_b  = bus.fq_valid_b ? queue_q[head_b].inst : '0;
    bus.fq_pc_b    = bus.fq_valid_b ? queue_q[head_b].pc   : '0;
  end

`ifdef TRITONE_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (bus.fetch_en && (count_q > CNT_W'(QUEUE_DEPTH - 2)) && (perf_stall_cycles != 16'hFFFF))
        perf_stall_cycles <= perf_stall_cycles + 16'd1;
      if (bus.redirect_valid && (perf_redirects != 16'hFFFF))
        perf_redirects <= perf_redirects + 16'd1;
    end
  end
`endif

endmodule
